// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq -- multi-nibble add/subtract sequencer
//
// Performs one W = 4*NIBBLES bit add or subtract, one nibble per clock, through
// a single 4-bit add/sub slice (addsub4bit). Operands are latched when a
// request is accepted, and the result register is filled nibble by nibble,
// least significant nibble first.
//
// Optional build macro:
//   ADDSUB_SEQ_ZERO_FLAG_EN  adds a registered 'zero' output flag
//
// Ports (addsub_seq):
//   clk     in   system clock, rising edge
//   rst     in   synchronous, active-high reset
//   start   in   request, sampled in IDLE and DONE only
//   op_sub  in   0 = a+b, 1 = a-b; sampled with start
//   a, b    in   W-bit operands; sampled with start
//   busy    out  high while nibbles are being processed
//   done    out  one-cycle pulse, result/flags valid
//   result  out  W-bit sum/difference (registered)
//   cout    out  final carry out (subtract: 1 = no borrow)
//   ovf     out  two's-complement overflow
//   zero    out  result == 0 (only with ADDSUB_SEQ_ZERO_FLAG_EN)
//
// Ports (addsub4bit):
//   a, bo, cin  in   nibble operand, pre-inverted operand, carry in
//   s, co       out  nibble sum, carry out
// -----------------------------------------------------------------------------

module addsub4bit (
   input  logic [3:0] a,
   input  logic [3:0] bo,
   input  logic       cin,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] b_eff;
   logic [4:0] sum;

   // The slice folds cin into the operand inversion: the upstream driver
   // pre-XORs bo with (op_sub ^ carry), so after this XOR the effective
   // operand is b ^ op_sub while cin still acts as the chain carry.
   always_comb begin
      b_eff = bo ^ {4{cin}};
      sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
      s     = sum[3:0];
      co    = sum[4];
   end

endmodule

module addsub_seq #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   op_sub,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   ovf
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   ,
   output logic                   zero
`endif
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            op_sub_q;
   logic [CW-1:0]   cnt_q;
   logic            carry_q;
   logic [W-1:0]    result_q;
   logic            busy_q;
   logic            done_q;
   logic            cout_q;
   logic            ovf_q;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   logic            zero_q;
`endif

   // ---------------------------------------------------------------------
   // Slice operand selection and next-state datapath
   // ---------------------------------------------------------------------
   logic [3:0]      a_nib;
   logic [3:0]      b_nib;
   logic [3:0]      slice_bo;
   logic [3:0]      slice_s;
   logic            slice_co;
   logic [W-1:0]    result_d;
   logic            last_nib;
   logic            ovf_d;

   // Select the current nibble of each latched operand.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int unsigned n = 0; n < NIBBLES; n++) begin
         if (cnt_q == CW'(n)) begin
            a_nib = a_q[4*n +: 4];
            b_nib = b_q[4*n +: 4];
         end
      end
      // Pre-XOR with (op_sub ^ carry) so the slice's internal XOR with cin
      // leaves b ^ op_sub as the effective operand.
      slice_bo = b_nib ^ {4{op_sub_q ^ carry_q}};
   end

   addsub4bit u_slice (
      .a   (a_nib),
      .bo  (slice_bo),
      .cin (carry_q),
      .s   (slice_s),
      .co  (slice_co)
   );

   // Merge the slice sum into the current nibble of the result word; kept
   // separate from the operand mux so no combinational path appears to loop.
   always_comb begin
      result_d = result_q;
      for (int unsigned n = 0; n < NIBBLES; n++) begin
         if (cnt_q == CW'(n)) begin
            result_d[4*n +: 4] = slice_s;
         end
      end
      last_nib = (cnt_q == CW'(NIBBLES - 1));
      // Signed overflow: operands (after subtract inversion) share a sign
      // that differs from the sign of the final sum.
      ovf_d    = (a_q[W-1] == (b_q[W-1] ^ op_sub_q)) && (slice_s[3] != a_q[W-1]);
   end

   // ---------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_sub_q <= 1'b0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
         zero_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               // DONE accepts a new request exactly like IDLE (back-to-back).
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  op_sub_q <= op_sub;
                  cnt_q    <= '0;
                  carry_q  <= op_sub;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end

            RUN: begin
               result_q <= result_d;
               carry_q  <= slice_co;
               cnt_q    <= cnt_q + CW'(1);
               if (last_nib) begin
                  cout_q  <= slice_co;
                  ovf_q   <= ovf_d;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
                  zero_q  <= (result_d == '0);
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_seq -- self-checking bench for addsub_seq (NIBBLES = 4).
// Directed vector table, hand-written multi-cycle sequences, and random
// operations compared against an arithmetic reference model.
// -----------------------------------------------------------------------------

module tb_addsub_seq;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          op_sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cout;
   logic          ovf;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
   logic          zero;
`endif

   int checks   = 0;
   int failures = 0;

   addsub_seq #(.NIBBLES(NIB)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      ,
      .zero   (zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] res;
      logic         c;
      logic         v;
   } vec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the full words.
   function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic c, output logic v);
      longint ux, uy, sx, sy, sr;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (!o) begin
         r  = W'(ux + uy);
         c  = (ux + uy) >= (longint'(1) << W);
         sr = sx + sy;
      end else begin
         r  = W'(ux - uy);
         c  = (ux >= uy);
         sr = sx - sy;
      end
      v = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
   endfunction

   // Present a request for one cycle; returns just after the accepting edge
   // with start dropped and the operand inputs scrambled.
   task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start  = 1'b1;
      op_sub = o;
      a      = x;
      b      = y;
      @(posedge clk);
      #1;
      start  = 1'b0;
      op_sub = 1'($urandom);
      a      = W'($urandom);
      b      = W'($urandom);
   endtask

   // Wait (bounded) for the done pulse, counting busy cycles on the way.
   task automatic run_to_done(input string tag, output int unsigned busy_cyc, output bit seen);
      busy_cyc = 0;
      seen     = 1'b0;
      for (int unsigned k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) busy_cyc++;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout: done=0 after 40 cycles, required done=1", tag);
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] er, input logic ec, input logic ev);
      chk({tag, "_result"}, result, er);
      chk({tag, "_cout"}, W'(cout), W'(ec));
      chk({tag, "_ovf"}, W'(ovf), W'(ev));
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
      chk({tag, "_zero"}, W'(zero), W'(er == '0));
`endif
   endtask

   // Full single operation with latency, pulse-width and result checks.
   task automatic do_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ec, input logic ev);
      int unsigned bc;
      bit          seen;
      issue(o, x, y);
      run_to_done(tag, bc, seen);
      chk({tag, "_busycycles"}, W'(bc), W'(NIB));
      check_result(tag, er, ec, ev);
      @(negedge clk);
      chk({tag, "_donepulse"}, W'(done), '0);
      chk({tag, "_hold"}, result, er);
   endtask

   initial begin
      vec_t           vt[$];
      int unsigned    bc;
      bit             seen;
      int unsigned    dones;
      logic [W-1:0]   mr;
      logic           mc, mv, ro;
      logic [W-1:0]   rx, ry;

      vt.push_back('{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0});
      vt.push_back('{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0});
      vt.push_back('{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0});
      vt.push_back('{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1});
      vt.push_back('{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1});
      vt.push_back('{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
      vt.push_back('{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0});
      vt.push_back('{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1});

      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", W'(busy), '0);
      chk("reset_done", W'(done), '0);
      chk("reset_result", result, '0);
      chk("reset_cout", W'(cout), '0);
      chk("reset_ovf", W'(ovf), '0);
      rst = 1'b0;

      // Directed vector table.
      for (int i = 0; i < vt.size(); i++) begin
         do_op($sformatf("vec%0d", i), vt[i].op, vt[i].x, vt[i].y, vt[i].res, vt[i].c, vt[i].v);
      end

      // Extra start during RUN is ignored.
      issue(1'b0, 16'h1000, 16'h0234);
      @(negedge clk);
      start = 1'b1;
      a     = 16'h1111;
      b     = 16'h1111;
      @(posedge clk);
      #1;
      start = 1'b0;
      run_to_done("ignore", bc, seen);
      check_result("ignore", 16'h1234, 1'b0, 1'b0);
      @(negedge clk);
      chk("ignore_not_queued", W'(busy), '0);

      // start held in the DONE cycle: accepted back-to-back.
      issue(1'b0, 16'h0100, 16'h0023);
      run_to_done("b2b_first", bc, seen);
      check_result("b2b_first", 16'h0123, 1'b0, 1'b0);
      start  = 1'b1;
      op_sub = 1'b1;
      a      = 16'h0050;
      b      = 16'h0010;
      @(posedge clk);
      #1;
      start  = 1'b0;
      @(negedge clk);
      chk("b2b_busy", W'(busy), W'(1));
      chk("b2b_nodone", W'(done), '0);
      run_to_done("b2b_second", bc, seen);
      check_result("b2b_second", 16'h0040, 1'b1, 1'b0);

      // Reset in RUN cycle 2 aborts without a done pulse.
      issue(1'b0, 16'h1111, 16'h2222);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", W'(busy), '0);
      chk("abort_done", W'(done), '0);
      chk("abort_result", result, '0);
      chk("abort_cout", W'(cout), '0);
      chk("abort_ovf", W'(ovf), '0);
      rst   = 1'b0;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      chk("abort_quiet", W'(dones), '0);
      do_op("after_abort", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

      // Random operations against the reference model.
      for (int i = 0; i < 60; i++) begin
         ro = 1'($urandom);
         rx = W'($urandom);
         ry = W'($urandom);
         if (i % 10 == 0) ry = rx;
         if (i % 10 == 1) ry = ~rx;
         model(ro, rx, ry, mr, mc, mv);
         do_op($sformatf("rand%0d", i), ro, rx, ry, mr, mc, mv);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
